// File: rtl/bell_pkg.sv
// Shared definitions for the bell-round controller.
//   state_t       : controller state encoding
//   *_DEF         : default target sum, win margin and lockout length
//   COLOR_*       : card colour encoding for the 2-bit colour field
package bell_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_JUDGE,
    S_AWARD,
    S_LOCKOUT,
    S_OVER
  } state_t;

  localparam int TARGET_DEF      = 5;
  localparam int WIN_MARGIN_DEF  = 50;
  localparam int LOCKOUT_CYC_DEF = 4;

  localparam logic [1:0] COLOR_RED    = 2'd0;
  localparam logic [1:0] COLOR_GREEN  = 2'd1;
  localparam logic [1:0] COLOR_BLUE   = 2'd2;
  localparam logic [1:0] COLOR_YELLOW = 2'd3;

endpackage

// File: rtl/bell_round_ctrl_if.sv
// Bus between the keypad/card front end and the bell-round controller.
//   master : drives new_game, bell_press, card_valid, card_color, card_num, pot;
//            observes grant, right, scores, winner, game_over, busy
//   slave  : the controller side (mirror directions)
interface bell_round_ctrl_if #(
  parameter int N_PLAYERS = 4,
  parameter int COLOR_W   = 2,
  parameter int NUM_W     = 3,
  parameter int POT_W     = 8,
  parameter int SCORE_W   = 9
);
  logic                           new_game;
  logic [N_PLAYERS-1:0]           bell_press;
  logic [N_PLAYERS-1:0]           card_valid;
  logic [N_PLAYERS*COLOR_W-1:0]   card_color;
  logic [N_PLAYERS*NUM_W-1:0]     card_num;
  logic [POT_W-1:0]               pot;
  logic [N_PLAYERS-1:0]           grant;
  logic                           right;
  logic [N_PLAYERS*SCORE_W-1:0]   scores;
  logic [N_PLAYERS-1:0]           winner;
  logic                           game_over;
  logic                           busy;

  modport master (
    output new_game, bell_press, card_valid, card_color, card_num, pot,
    input  grant, right, scores, winner, game_over, busy
  );

  modport slave (
    input  new_game, bell_press, card_valid, card_color, card_num, pot,
    output grant, right, scores, winner, game_over, busy
  );
endinterface

// File: rtl/bell_rr_arbiter.sv
// N-way round-robin one-hot arbiter.
//   clk, rst (async, active-low)
//   clear   : synchronous pointer reset to player 0
//   advance : move the pointer past the current grant
//   req     : request vector
//   grant   : combinational one-hot grant (zero when no request)
module bell_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         advance,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [PTR_W-1:0] idx;

  // Scan from lowest to highest priority so the last hit (closest to ptr) wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = PTR_W'((int'(ptr) + off) % N);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_nxt = ptr;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) ptr_nxt = PTR_W'((i + 1) % N);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ptr <= '0;
    else if (clear)   ptr <= '0;
    else if (advance) ptr <= ptr_nxt;
  end
endmodule

// File: rtl/bell_round_ctrl.sv
// N-player bell-round controller: press edge detect, round-robin arbitration,
// colour-sum judgement, saturating signed score update and win detection.
//   clk, rst (async, active-low)
//   bus : bell_round_ctrl_if.slave (inputs new_game, bell_press, card_*, pot;
//         outputs grant, right, scores, winner, game_over, busy)
// Build option: define BELL_PENALTY_EN to make a wrong bell cost the presser
// N_PLAYERS-1 points and give every other player 1 point.
module bell_round_ctrl
  import bell_pkg::*;
#(
  parameter int N_PLAYERS   = 4,
  parameter int COLOR_W     = 2,
  parameter int NUM_W       = 3,
  parameter int TARGET      = TARGET_DEF,
  parameter int POT_W       = 8,
  parameter int SCORE_W     = 9,
  parameter int WIN_MARGIN  = WIN_MARGIN_DEF,
  parameter int LOCKOUT_CYC = LOCKOUT_CYC_DEF
) (
  input logic              clk,
  input logic              rst,
  bell_round_ctrl_if.slave bus
);
  localparam int N_COLORS = 1 << COLOR_W;
  localparam int SUM_W    = NUM_W + $clog2(N_PLAYERS);
  localparam int CNT_W    = $clog2(LOCKOUT_CYC + 1);
  localparam logic [CNT_W-1:0]     LOCK_LAST = CNT_W'(LOCKOUT_CYC - 1);
  localparam logic signed [SCORE_W:0] MARGIN = (SCORE_W + 1)'(WIN_MARGIN);
`ifdef BELL_PENALTY_EN
  localparam logic signed [SCORE_W:0] PENALTY = (SCORE_W + 1)'(N_PLAYERS - 1);
  localparam logic signed [SCORE_W:0] ONE     = (SCORE_W + 1)'(1);
`endif

  function automatic logic signed [SCORE_W-1:0] sat_score(input logic signed [SCORE_W:0] v);
    if (v[SCORE_W] != v[SCORE_W-1])
      sat_score = v[SCORE_W] ? {1'b1, {(SCORE_W-1){1'b0}}} : {1'b0, {(SCORE_W-1){1'b1}}};
    else
      sat_score = v[SCORE_W-1:0];
  endfunction

  state_t                        state;
  logic [CNT_W-1:0]              lock_cnt;
  logic [N_PLAYERS-1:0]          press_prev, press_edge, arb_req, arb_grant;
  logic                          arb_advance;
  logic [N_PLAYERS-1:0]          pres_p0, valid_p0;
  logic [N_PLAYERS*COLOR_W-1:0]  color_p0;
  logic [N_PLAYERS*NUM_W-1:0]    num_p0;
  logic [POT_W-1:0]              pot_p0;
  logic [SUM_W-1:0]              col_sum;
  logic                          right_judge, right_p1;
  logic signed [SCORE_W-1:0]     score_q   [N_PLAYERS];
  logic signed [SCORE_W-1:0]     score_nxt [N_PLAYERS];
  logic [N_PLAYERS-1:0]          win_vec, grant_q, winner_q;
  logic                          right_q, game_over_q;

  assign press_edge  = bus.bell_press & ~press_prev;
  assign arb_req     = (state == S_IDLE) ? press_edge : '0;
  assign arb_advance = (state == S_IDLE) && (|press_edge);

  bell_rr_arbiter #(.N(N_PLAYERS)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .clear  (bus.new_game),
    .advance(arb_advance),
    .req    (arb_req),
    .grant  (arb_grant)
  );

  // Stage p0: card snapshot taken with the accepted press
  always_ff @(posedge clk) begin
    if (state == S_IDLE && (|press_edge)) begin
      valid_p0 <= bus.card_valid;
      color_p0 <= bus.card_color;
      num_p0   <= bus.card_num;
      pot_p0   <= bus.pot;
    end
  end

  always_comb begin
    right_judge = 1'b0;
    col_sum     = '0;
    for (int c = 0; c < N_COLORS; c++) begin
      col_sum = '0;
      for (int i = 0; i < N_PLAYERS; i++) begin
        if (valid_p0[i] && color_p0[i*COLOR_W +: COLOR_W] == COLOR_W'(c))
          col_sum = col_sum + SUM_W'(num_p0[i*NUM_W +: NUM_W]);
      end
      if (col_sum == SUM_W'(TARGET)) right_judge = 1'b1;
    end
  end

  // Stage p1 -> p2: score update applied in AWARD
  always_comb begin
    for (int i = 0; i < N_PLAYERS; i++) begin
      score_nxt[i] = score_q[i];
      if (pres_p0[i] && right_p1)
        score_nxt[i] = sat_score($signed({score_q[i][SCORE_W-1], score_q[i]})
                                 + $signed((SCORE_W + 1)'(pot_p0)));
`ifdef BELL_PENALTY_EN
      else if (pres_p0[i])
        score_nxt[i] = sat_score($signed({score_q[i][SCORE_W-1], score_q[i]}) - PENALTY);
      else if (!right_p1)
        score_nxt[i] = sat_score($signed({score_q[i][SCORE_W-1], score_q[i]}) + ONE);
`endif
    end
  end

  always_comb begin
    win_vec = '1;
    for (int i = 0; i < N_PLAYERS; i++) begin
      for (int j = 0; j < N_PLAYERS; j++) begin
        if (j != i && ($signed({score_q[i][SCORE_W-1], score_q[i]}) <
                       $signed({score_q[j][SCORE_W-1], score_q[j]}) + MARGIN))
          win_vec[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      lock_cnt    <= '0;
      press_prev  <= '0;
      pres_p0     <= '0;
      right_p1    <= 1'b0;
      grant_q     <= '0;
      right_q     <= 1'b0;
      winner_q    <= '0;
      game_over_q <= 1'b0;
      for (int i = 0; i < N_PLAYERS; i++) score_q[i] <= '0;
    end else if (bus.new_game) begin
      state       <= S_IDLE;
      lock_cnt    <= '0;
      press_prev  <= bus.bell_press;
      pres_p0     <= '0;
      right_p1    <= 1'b0;
      grant_q     <= '0;
      right_q     <= 1'b0;
      winner_q    <= '0;
      game_over_q <= 1'b0;
      for (int i = 0; i < N_PLAYERS; i++) score_q[i] <= '0;
    end else begin
      press_prev <= bus.bell_press;
      grant_q    <= '0;
      right_q    <= 1'b0;
      if (!game_over_q && (|win_vec)) begin
        winner_q    <= win_vec;
        game_over_q <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (|press_edge) begin
            pres_p0 <= arb_grant;
            state   <= S_JUDGE;
          end
        end
        S_JUDGE: begin
          right_p1 <= right_judge;
          state    <= S_AWARD;
        end
        S_AWARD: begin
          for (int i = 0; i < N_PLAYERS; i++) score_q[i] <= score_nxt[i];
          grant_q  <= pres_p0;
          right_q  <= right_p1;
          lock_cnt <= '0;
          state    <= S_LOCKOUT;
        end
        S_LOCKOUT: begin
          // win_vec covers a 1-cycle lockout where game_over is not yet registered
          if (lock_cnt == LOCK_LAST)
            state <= (game_over_q || (|win_vec)) ? S_OVER : S_IDLE;
          else
            lock_cnt <= lock_cnt + 1'b1;
        end
        S_OVER:  state <= S_OVER;
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_scores
    assign bus.scores[g*SCORE_W +: SCORE_W] = score_q[g];
  end

  assign bus.grant     = grant_q;
  assign bus.right     = right_q;
  assign bus.winner    = winner_q;
  assign bus.game_over = game_over_q;
  assign bus.busy      = (state != S_IDLE);
endmodule

// File: doc/bell_round_ctrl.md
# bell_round_ctrl

N-player bell-round controller for the inner-bell card game. It detects bell presses and arbitrates simultaneous presses round-robin. It judges the face-up cards against the target sum, updates every player's signed score, and declares a winner once one player leads all others by a fixed margin. It sits between the keypad decode and the LCD/score display logic, and replaces the fixed two-player judge/press/score/winner chain with one parametrised sequential block.

## Interface
- N_PLAYERS, 4: number of players, 2..8
- COLOR_W, 2: card colour width
- NUM_W, 3: card number width
- TARGET, 5: bell is right when any colour's visible sum equals this
- POT_W, 8: width of the pot (cards awarded on a right bell)
- SCORE_W, 9: signed score width per player
- WIN_MARGIN, 50: lead over every other player needed to win
- LOCKOUT_CYC, 4: cycles of press lockout after each award, ≥1

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- new_game  in  1  synchronous clear of scores, game_over and arbiter; overrides everything except rst
- bell_press  in  N_PLAYERS  level press per player; rising edge detected internally
- card_valid  in  N_PLAYERS  player has a face-up card
- card_color  in  N_PLAYERS*COLOR_W  face-up colour, player i at [i*COLOR_W +: COLOR_W]
- card_num  in  N_PLAYERS*NUM_W  face-up number, same packing
- pot  in  POT_W  unsigned award amount
- grant  out  N_PLAYERS  one-hot, 1-cycle pulse identifying the judged presser
- right  out  1  judgement, valid only while grant≠0
- scores  out  N_PLAYERS*SCORE_W  signed two's-complement scores
- winner  out  N_PLAYERS  one-hot winner, held until new_game
- game_over  out  1  held until new_game
- busy  out  1  state≠IDLE

## Operation
- States: IDLE, JUDGE, AWARD, LOCKOUT, OVER.
- Press edge: bell_press[i]=1 while the registered previous value is 0. Edges seen outside IDLE are discarded. A held press never retriggers.
- IDLE: if any edge, the arbiter picks one player and the state goes to JUDGE. The card snapshot (valid/color/num) and pot are captured on the same edge.
- Arbiter: round-robin. Priority starts at the player after the last grant. After reset or new_game, player 0 has highest priority.
- JUDGE: for each colour c, sum card_num over valid players with colour c. The sum width is NUM_W+clog2(N_PLAYERS), so there is no overflow. right = any sum == TARGET. The state goes to AWARD.
- AWARD: on a right bell, the presser's score increases by pot (zero-extended). On a wrong bell, the presser's score decreases by N_PLAYERS−1 and each other player's score increases by 1. The state goes to LOCKOUT.
- Score arithmetic is computed at SCORE_W+1 bits and saturated to the signed SCORE_W range.
- LOCKOUT: count LOCKOUT_CYC cycles, then go to IDLE. If game_over is set, go to OVER instead.
- Win check: player i wins when score_i ≥ score_j + WIN_MARGIN for every j≠i, compared at SCORE_W+1 bits signed. At most one player can satisfy this.
- OVER: all presses are ignored. Only new_game or rst leaves OVER.
- new_game: scores=0, winner=0, game_over=0, arbiter pointer=0, state=IDLE, edge history=current bell_press.

## Timing
- Reset values: every output is 0, all scores are 0, state=IDLE, and the arbiter pointer is 0. Reset takes effect immediately in any state, including mid-AWARD, and no score update is performed.
- Press edge sampled at clock edge E0. JUDGE runs during E0→E1 and AWARD during E1→E2. Scores update at E2.
- After E2, grant and right are high for exactly one cycle, coincident with the new scores.
- winner and game_over are registered at E3 from the updated scores.
- The next press can be accepted no earlier than E2+LOCKOUT_CYC.
- busy is high from E0 until the return to IDLE.
- Simultaneous edges in one cycle produce exactly one grant. The losing edges are discarded, not queued.

## Configuration
- BELL_PENALTY_EN defined: a wrong bell applies the penalty described under AWARD.
- BELL_PENALTY_EN undefined: a wrong bell changes no score. The block still pulses grant with right=0 and still enters LOCKOUT.

## Structure
- Shared package bell_pkg holds:
  - the state enum
  - defaults for TARGET, WIN_MARGIN and LOCKOUT_CYC
  - the colour encoding constants
- Sub-module bell_rr_arbiter: N-way round-robin one-hot arbiter with a registered pointer and an advance-on-grant input.
- The colour-sum judge and score update stay in the top module.

## Test plan
- N=4. Cards P0 red 2, P1 red 3, P2 green 4, P3 invalid; pot=6; P1 presses → grant=0010, right=1, score1=6 at E2. Other scores unchanged.
- Cards red 1, green 2, blue 3, yellow 4 (no colour sums to 5); P0 presses → right=0, score0=−3, scores 1..3=+1. With BELL_PENALTY_EN undefined, all scores stay 0.
- Last grant P1; P0 and P2 edges in the same cycle → grant=0100. Repeat the simultaneous press after lockout → grant=0001.
- P3 presses during LOCKOUT and keeps holding → no grant. A press held across the return to IDLE → no grant until a release and a new press.
- WIN_MARGIN=50; P0=48, others 0; P0 right bell with pot=3 → score0=51, winner=0001 and game_over=1 at E3. Later presses ignored; new_game clears scores and flags.
- rst asserted while state=AWARD → outputs 0 immediately and no score change. With score0 saturated at +255 (SCORE_W=9), a right bell with pot=10 → score0 stays 255.
